// File: rtl/vga_capture_pkg.sv
// Shared constants, PMOD pin map and lock-FSM state type for the VGA PMOD capture block.
package vga_capture_pkg;

  localparam int VGA_H_ACTIVE_START  = 144;
  localparam int VGA_H_DISPLAY       = 640;
  localparam int VGA_H_TOTAL         = 800;
  localparam int VGA_V_ACTIVE_START  = 35;
  localparam int VGA_V_DISPLAY       = 480;
  localparam int VGA_V_TOTAL         = 525;
  localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;

  localparam int PMOD_B0    = 0;
  localparam int PMOD_G0    = 1;
  localparam int PMOD_R0    = 2;
  localparam int PMOD_VSYNC = 3;
  localparam int PMOD_B1    = 4;
  localparam int PMOD_G1    = 5;
  localparam int PMOD_R1    = 6;
  localparam int PMOD_HSYNC = 7;

  localparam logic [10:0] HCOUNT_MAX = 11'd2047;
  localparam logic [9:0]  VCOUNT_MAX = 10'd1023;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } capture_state_t;

  // Colour word ordering as seen by downstream consumers of pix_rgb.
  function automatic logic [5:0] pmod_rgb(input logic [7:0] b);
    return {b[PMOD_B0], b[PMOD_B1], b[PMOD_G0], b[PMOD_G1], b[PMOD_R0], b[PMOD_R1]};
  endfunction

endpackage

// File: rtl/crc16_step6.sv
// One-cycle CRC-16-CCITT (poly 0x1021) update absorbing 6 data bits, MSB first.
module crc16_step6 (
  input  logic [15:0] crc,
  input  logic [5:0]  data,
  output logic [15:0] crc_next
);

  logic [15:0] c;

  always_comb begin
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/vga_pmod_capture.sv
// Receive-side VGA PMOD monitor: sync recovery, pixel coordinates, timing lock FSM, frame signature.
// Define VGA_CAPTURE_CRC_EN to build the per-frame CRC; otherwise frame_crc is tied to 0.
module vga_pmod_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE_START  = VGA_H_ACTIVE_START,
  parameter int H_DISPLAY       = VGA_H_DISPLAY,
  parameter int H_TOTAL         = VGA_H_TOTAL,
  parameter int V_ACTIVE_START  = VGA_V_ACTIVE_START,
  parameter int V_DISPLAY       = VGA_V_DISPLAY,
  parameter int V_TOTAL         = VGA_V_TOTAL,
  parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pmod_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [10:0] h_period,
  output logic [9:0]  lines_per_frame,
  output logic [15:0] frame_crc,
  output logic        locked
);

  localparam logic [10:0] H_START = 11'(H_ACTIVE_START);
  localparam logic [10:0] H_END   = 11'(H_ACTIVE_START + H_DISPLAY);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [9:0]  V_START = 10'(V_ACTIVE_START);
  localparam logic [9:0]  V_END   = 10'(V_ACTIVE_START + V_DISPLAY);
  localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);

  logic [7:0]     s1;
  logic           hs_prev_raw, vs_prev_raw;
  logic           hs_act, vs_act, hs_prev_act, vs_prev_act;
  logic           h_edge, v_edge;
  logic [10:0]    hcount, h_inc, h_next;
  logic [9:0]     vcount, v_inc, v_next, lpf_next;
  logic [5:0]     rgb_s1;
  logic           visible, h_sat, line_bad, frame_bad, frame_good;
  capture_state_t state;

  // Raw pin history is kept (not the "active" flag) so all-zero reset state never fakes an edge.
  assign hs_act      = s1[PMOD_HSYNC] ^ SYNC_ACTIVE_LOW;
  assign vs_act      = s1[PMOD_VSYNC] ^ SYNC_ACTIVE_LOW;
  assign hs_prev_act = hs_prev_raw ^ SYNC_ACTIVE_LOW;
  assign vs_prev_act = vs_prev_raw ^ SYNC_ACTIVE_LOW;
  assign h_edge      = hs_act & ~hs_prev_act;
  assign v_edge      = vs_act & ~vs_prev_act;
  assign rgb_s1      = pmod_rgb(s1);

  assign h_inc    = (hcount == HCOUNT_MAX) ? HCOUNT_MAX : hcount + 11'd1;
  assign v_inc    = (vcount == VCOUNT_MAX) ? VCOUNT_MAX : vcount + 10'd1;
  assign h_next   = h_edge ? 11'd0 : h_inc;
  assign lpf_next = h_edge ? v_inc : vcount;

  always_comb begin
    v_next = vcount;
    if (v_edge)      v_next = h_edge ? 10'd1 : 10'd0;
    else if (h_edge) v_next = v_inc;
  end

  assign visible    = (h_next >= H_START) && (h_next < H_END) &&
                      (v_next >= V_START) && (v_next < V_END);
  assign h_sat      = (h_next == HCOUNT_MAX);
  assign line_bad   = h_edge && (h_inc != H_TOT);
  assign frame_good = !(frame_bad || line_bad) && (lpf_next == V_TOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= '0;
      hs_prev_raw <= 1'b0;
      vs_prev_raw <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      h_period    <= '0;
    end else begin
      s1          <= pmod_in;
      hs_prev_raw <= s1[PMOD_HSYNC];
      vs_prev_raw <= s1[PMOD_VSYNC];
      hcount      <= h_next;
      vcount      <= v_next;
      if (h_edge) h_period <= h_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= visible && (state != SEARCH);
      if (visible) begin
        pix_x   <= 10'(h_next - H_START);
        pix_y   <= v_next - V_START;
        pix_rgb <= rgb_s1;
      end
    end
  end

  // Lock FSM; losing hsync entirely (hcount saturation) overrides any vsync decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SEARCH;
      locked          <= 1'b0;
      frame_done      <= 1'b0;
      lines_per_frame <= '0;
      frame_bad       <= 1'b0;
    end else begin
      frame_done <= v_edge;
      if (v_edge) begin
        lines_per_frame <= lpf_next;
        frame_bad       <= 1'b0;
      end else if (line_bad) begin
        frame_bad <= 1'b1;
      end
      case (state)
        SEARCH:  if (v_edge) state <= ACQUIRE;
        ACQUIRE: if (v_edge && frame_good) begin
          state  <= LOCKED;
          locked <= 1'b1;
        end
        LOCKED:  if (v_edge && !frame_good) begin
          state  <= ACQUIRE;
          locked <= 1'b0;
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
      if (h_sat) begin
        state  <= SEARCH;
        locked <= 1'b0;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_run, crc_step;

  crc16_step6 u_crc (
    .crc      (crc_run),
    .data     (rgb_s1),
    .crc_next (crc_step)
  );

  // Reset value 0 (not CRC_INIT) so nothing gathered before the first vsync edge counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= '0;
      frame_crc <= '0;
    end else if (v_edge) begin
      frame_crc <= crc_run;
      crc_run   <= CRC_INIT;
    end else if (visible && (state != SEARCH)) begin
      crc_run <= crc_step;
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Directed bench for vga_pmod_capture using a shrunken 64x32 raster so whole frames stay short.
module tb_vga_pmod_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pmod_in;
  logic [9:0]  pix_x, pix_y, lines_per_frame;
  logic [5:0]  pix_rgb;
  logic        pix_valid, frame_done, locked;
  logic [10:0] h_period;
  logic [15:0] frame_crc;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int mark_cyc = -100;
  int fd_n     = 0;
  int vcnt     = 0;
  logic [31:0] fd_locked[16], fd_lpf[16], fd_hper[16], fd_crc[16], fd_valid[16];

  vga_pmod_capture #(
    .H_ACTIVE_START  (16),
    .H_DISPLAY       (32),
    .H_TOTAL         (64),
    .V_ACTIVE_START  (4),
    .V_DISPLAY       (24),
    .V_TOTAL         (32),
    .SYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pmod_in         (pmod_in),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_rgb         (pix_rgb),
    .pix_valid       (pix_valid),
    .frame_done      (frame_done),
    .h_period        (h_period),
    .lines_per_frame (lines_per_frame),
    .frame_crc       (frame_crc),
    .locked          (locked)
  );

  always #5 clk = ~clk;

  // Pin byte {hsync, R1, G1, B1, vsync, R0, G0, B0} with syncs asserted low.
  function automatic logic [7:0] pmodByte(input logic hs, input logic vs, input logic [5:0] rgb);
    return {~hs, rgb[0], rgb[2], rgb[4], ~vs, rgb[1], rgb[3], rgb[5]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Outputs seen at a negedge belong to the pin byte driven two negedges earlier.
  task automatic applyStimulus(input logic [7:0] pins, input bit is_mark);
    @(negedge clk);
    if (cyc == mark_cyc + 1) begin
      checkOutput("mark_minus1_valid", {31'd0, pix_valid}, 32'd1);
      checkOutput("mark_minus1_x", {22'd0, pix_x}, 32'd9);
      checkOutput("mark_minus1_rgb", {26'd0, pix_rgb}, 32'd0);
    end
    if (cyc == mark_cyc + 2) begin
      checkOutput("mark_valid", {31'd0, pix_valid}, 32'd1);
      checkOutput("mark_x", {22'd0, pix_x}, 32'd10);
      checkOutput("mark_y", {22'd0, pix_y}, 32'd20);
      checkOutput("mark_rgb", {26'd0, pix_rgb}, 32'b110001);
    end
    if (frame_done === 1'b1) begin
      if (fd_n < 16) begin
        fd_locked[fd_n] = {31'd0, locked};
        fd_lpf[fd_n]    = {22'd0, lines_per_frame};
        fd_hper[fd_n]   = {21'd0, h_period};
        fd_crc[fd_n]    = {16'd0, frame_crc};
        fd_valid[fd_n]  = vcnt;
      end
      fd_n++;
      vcnt = 0;
    end else if (pix_valid === 1'b1) begin
      vcnt++;
    end
    if (is_mark) mark_cyc = cyc;
    pmod_in = pins;
    cyc++;
  endtask

  task automatic driveFrame(input int vs_off, input bit stretch, input bit mark, input int max_cycles);
    int n;
    int cols;
    int p;
    bit m;
    n = 0;
    for (int ln = 0; ln < 32; ln++) begin
      cols = (stretch && ln == 10) ? 65 : 64;
      for (int col = 0; col < cols; col++) begin
        if (n >= max_cycles) return;
        p = ln * 64 + col;
        m = mark && (ln == 24) && (col == 26);
        applyStimulus(pmodByte(col < 8, (p >= vs_off) && (p < vs_off + 128),
                               m ? 6'b110001 : 6'd0), m);
        n++;
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pmod_in = 8'h88;
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("rst_h_period", {21'd0, h_period}, 32'd0);
    rst_n = 1'b1;

    repeat (2100) applyStimulus(8'h88, 1'b0);
    checkOutput("idle_pix_x", {22'd0, pix_x}, 32'd0);
    checkOutput("idle_pix_y", {22'd0, pix_y}, 32'd0);
    checkOutput("idle_pix_rgb", {26'd0, pix_rgb}, 32'd0);
    checkOutput("idle_pix_valid", {31'd0, pix_valid}, 32'd0);
    checkOutput("idle_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("idle_h_period", {21'd0, h_period}, 32'd0);
    checkOutput("idle_lpf", {22'd0, lines_per_frame}, 32'd0);
    checkOutput("idle_frame_crc", {16'd0, frame_crc}, 32'd0);
    checkOutput("idle_locked", {31'd0, locked}, 32'd0);

    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b1, 100000);
    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b1, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(0, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b0, 100000);
    driveFrame(5, 1'b0, 1'b0, 10);
    repeat (3) applyStimulus(8'h88, 1'b0);

    checkOutput("frame_done_count", fd_n, 32'd10);
    checkOutput("fd0_locked", fd_locked[0], 32'd0);
    checkOutput("fd0_lpf", fd_lpf[0], 32'd1);
    checkOutput("fd1_locked", fd_locked[1], 32'd1);
    checkOutput("fd1_lpf", fd_lpf[1], 32'd32);
    checkOutput("fd1_valid_count", fd_valid[1], 32'd768);
    checkOutput("fd2_valid_count", fd_valid[2], 32'd768);
    checkOutput("fd2_h_period", fd_hper[2], 32'd64);
    checkOutput("fd4_locked", fd_locked[4], 32'd1);
    checkOutput("fd5_stretch_locked", fd_locked[5], 32'd0);
    checkOutput("fd5_lpf", fd_lpf[5], 32'd32);
    checkOutput("fd6_relock", fd_locked[6], 32'd1);
    checkOutput("fd7_locked", fd_locked[7], 32'd1);
    checkOutput("fd7_coincident_lpf", fd_lpf[7], 32'd32);
    checkOutput("fd8_after_coincident_lpf", fd_lpf[8], 32'd33);
    checkOutput("fd8_locked", fd_locked[8], 32'd0);
    checkOutput("fd9_locked", fd_locked[9], 32'd1);
`ifdef VGA_CAPTURE_CRC_EN
    checkOutput("crc_repeat_equal", fd_crc[4], fd_crc[2]);
    checkOutput("crc_nonzero", {31'd0, (fd_crc[2] != 32'd0)}, 32'd1);
    checkOutput("crc_pixel_change", {31'd0, (fd_crc[3] != fd_crc[2])}, 32'd1);
`else
    checkOutput("crc_off_fd2", fd_crc[2], 32'd0);
    checkOutput("crc_off_fd3", fd_crc[3], 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
